// File: rtl/hams_pkg.sv
// Shared HAMS types and constants: the pair type, the chunk width and the
// state encoding for the chunk-merge stage.
package hams_pkg;

    localparam int NUM_ELEMENTS = 4;
    localparam int PAIR_W       = 16;

    typedef logic [PAIR_W-1:0] pair_t;

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        MERGE  = 2'd2
    } merge_state_e;

    localparam int MERGE_RUN_LEN = 2 * NUM_ELEMENTS;

endpackage

// File: rtl/hams_chunk_merge_if.sv
// Chunk-in / serial-stream-out bundle for hams_chunk_merge.
// slave is the merge block's view, master is the view of whoever drives it.
interface hams_chunk_merge_if
    import hams_pkg::*;
#(
    parameter int NUM_ELEMENTS = hams_pkg::NUM_ELEMENTS
) ();

    pair_t [NUM_ELEMENTS-1:0] sorted_i;
    logic                     valid_i;
    logic                     ready_o;
    pair_t                    merged_o;
    logic                     valid_o;
    logic                     ready_i;
    logic                     last_o;

    modport slave (
        input  sorted_i, valid_i, ready_i,
        output ready_o, merged_o, valid_o, last_o
    );

    modport master (
        output sorted_i, valid_i, ready_i,
        input  ready_o, merged_o, valid_o, last_o
    );

endinterface

// File: rtl/hams_chunk_buf.sv
// One captured chunk plus its read pointer; head is the next unread pair,
// empty once the pointer has walked past the last entry.
module hams_chunk_buf
    import hams_pkg::*;
#(
    parameter int  N  = 4,
    localparam int PW = $clog2(N) + 1,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  pair_t [N-1:0]   data,
    input  logic            clear,
    input  logic            advance,
    output pair_t           head,
    output logic            empty
);

    pair_t [N-1:0] mem_r;
    logic [PW-1:0] ptr_r;

    // Chunk storage, no reset needed since contents are only read after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            mem_r <= data;
        end
    end

    // Read pointer; it is one bit wider than the index so it can reach N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {PW{1'b0}};
        end else if (clear) begin
            ptr_r <= {PW{1'b0}};
        end else if (advance && !empty) begin
            ptr_r <= ptr_r + PW'(1);
        end
    end

    // When empty the low bits wrap to 0, which is harmless as head is unused then.
    assign head  = mem_r[ptr_r[IW-1:0]];
    assign empty = (ptr_r == PW'(N));

    hams_chunk_buf_chk #(.N(N)) u_chk (
        .clk (clk),
        .rst (rst),
        .ptr (ptr_r)
    );

endmodule

// File: rtl/hams_chunk_buf_chk.sv
// Checker for hams_chunk_buf: the read pointer may reach N but never pass it.
module hams_chunk_buf_chk #(
    parameter int  N  = 4,
    localparam int PW = $clog2(N) + 1
) (
    input logic          clk,
    input logic          rst,
    input logic [PW-1:0] ptr
);

    ptr_in_range: assert property (@(posedge clk) disable iff (rst) ptr <= PW'(N));

endmodule

// File: rtl/hams_chunk_merge.sv
// Captures two sorted chunks and streams them out as one stable, ascending
// run of 2*NUM_ELEMENTS pairs under valid/ready backpressure.
module hams_chunk_merge
    import hams_pkg::*;
#(
    parameter int  NUM_ELEMENTS = hams_pkg::NUM_ELEMENTS,
    localparam int CW           = $clog2(2 * NUM_ELEMENTS)
) (
    input logic               clk,
    input logic               rst,
    hams_chunk_merge_if.slave bus
);

    merge_state_e  state_r;
    merge_state_e  state_next_s;
    logic [CW-1:0] cnt_r;
    pair_t         head_a_s;
    pair_t         head_b_s;
    logic          empty_a_s;
    logic          empty_b_s;
    logic          take_a_s;
    logic          accept_s;
    logic          xfer_s;
    logic          last_s;
    logic          load_a_s;
    logic          load_b_s;

    assign accept_s = bus.valid_i && (state_r != MERGE);
    assign load_a_s = accept_s && (state_r == FILL_A);
    assign load_b_s = accept_s && (state_r == FILL_B);
    assign last_s   = (state_r == MERGE) && (cnt_r == CW'(2 * NUM_ELEMENTS - 1));
    assign xfer_s   = (state_r == MERGE) && bus.ready_i;

    hams_chunk_buf #(.N(NUM_ELEMENTS)) u_buf_a (
        .clk     (clk),
        .rst     (rst),
        .load    (load_a_s),
        .data    (bus.sorted_i),
        .clear   (load_b_s),
        .advance (xfer_s && take_a_s),
        .head    (head_a_s),
        .empty   (empty_a_s)
    );

    hams_chunk_buf #(.N(NUM_ELEMENTS)) u_buf_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load_b_s),
        .data    (bus.sorted_i),
        .clear   (load_b_s),
        .advance (xfer_s && !take_a_s),
        .head    (head_b_s),
        .empty   (empty_b_s)
    );

    // Head select: an exhausted side loses; ties go to A to keep the merge stable.
    always_comb begin
        take_a_s = 1'b0;
        if (empty_a_s) begin
            take_a_s = 1'b0;
        end else if (empty_b_s) begin
            take_a_s = 1'b1;
        end else begin
            take_a_s = (head_a_s <= head_b_s);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FILL_A;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FILL_A: begin
                if (accept_s) state_next_s = FILL_B;
                else          state_next_s = FILL_A;
            end
            FILL_B: begin
                if (accept_s) state_next_s = MERGE;
                else          state_next_s = FILL_B;
            end
            MERGE: begin
                if (xfer_s && last_s) state_next_s = FILL_A;
                else                  state_next_s = MERGE;
            end
            default: state_next_s = FILL_A;
        endcase
    end

    // Output counter; it wraps to zero on the final transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load_b_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (xfer_s) begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign bus.ready_o  = (state_r != MERGE);
    assign bus.valid_o  = (state_r == MERGE);
    assign bus.last_o   = last_s;
    assign bus.merged_o = take_a_s ? head_a_s : head_b_s;

endmodule

// File: tb/tb_hams_chunk_merge.sv
// Directed bench for hams_chunk_merge with NUM_ELEMENTS=4: a table of merge
// runs plus hand-written idle, offer-during-merge and mid-run reset sequences.
module tb_hams_chunk_merge;
    import hams_pkg::*;

    localparam int N = 4;

    typedef pair_t [N-1:0]   chunk_t;
    typedef pair_t [2*N-1:0] run_t;

    typedef struct {
        chunk_t          a;
        chunk_t          b;
        run_t            exp;
        logic [2*N-1:0]  src;   // bit k set: k-th output must come from A
        logic [15:0]     rdy;   // ready_i pattern, bit c used on merge cycle c
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    hams_chunk_merge_if #(.NUM_ELEMENTS(N)) bus ();

    hams_chunk_merge #(.NUM_ELEMENTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic chunk_t mk4(input int p0, input int p1, input int p2, input int p3);
        return {pair_t'(p3), pair_t'(p2), pair_t'(p1), pair_t'(p0)};
    endfunction

    function automatic run_t mk8(input int p0, input int p1, input int p2, input int p3,
                                 input int p4, input int p5, input int p6, input int p7);
        return {pair_t'(p7), pair_t'(p6), pair_t'(p5), pair_t'(p4),
                pair_t'(p3), pair_t'(p2), pair_t'(p1), pair_t'(p0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; offers a chunk across one posedge.
    task automatic load_chunk(input chunk_t c);
        bus.sorted_i = c;
        bus.valid_i  = 1'b1;
        chk("ready_o_on_offer", 64'(bus.ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // Called at the negedge right after chunk B was accepted.
    task automatic drain(input run_t exp, input logic [2*N-1:0] src, input logic [15:0] rdy);
        int k;
        int cyc;
        logic [63:0] ia0;
        k   = 0;
        cyc = 0;
        while (k < 2 * N && cyc < 64) begin
            chk("valid_o", 64'(bus.valid_o), 64'd1);
            chk("merged_o", 64'(bus.merged_o), 64'(exp[k]));
            chk("last_o", 64'(bus.last_o), 64'(k == 2 * N - 1));
            chk("ready_o_in_merge", 64'(bus.ready_o), 64'd0);
            bus.ready_i = rdy[cyc % 16];
            ia0 = 64'(dut.u_buf_a.ptr_r);
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_i) begin
                chk("source_a", 64'(64'(dut.u_buf_a.ptr_r) != ia0), 64'(src[k]));
                k++;
            end
            cyc++;
        end
        if (k < 2 * N) chk("drain_timeout", 64'(k), 64'(2 * N));
        bus.ready_i = 1'b0;
        chk("ready_o_after_run", 64'(bus.ready_o), 64'd1);
        chk("valid_o_after_run", 64'(bus.valid_o), 64'd0);
    endtask

    initial begin
        vecs[0] = '{mk4(1, 3, 5, 7), mk4(2, 4, 6, 8), mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    8'b01010101, 16'hFFFF};
        vecs[1] = '{mk4(1, 2, 3, 4), mk4(5, 6, 7, 8), mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    8'b00001111, 16'hFFFF};
        vecs[2] = '{mk4(9, 9, 9, 9), mk4(9, 9, 9, 9), mk8(9, 9, 9, 9, 9, 9, 9, 9),
                    8'b00001111, 16'hFFFF};
        vecs[3] = '{mk4(1, 3, 5, 7), mk4(2, 4, 6, 8), mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    8'b01010101, 16'h9999};
        vecs[4] = '{mk4(5, 6, 7, 8), mk4(1, 2, 3, 4), mk8(1, 2, 3, 4, 5, 6, 7, 8),
                    8'b11110000, 16'hAAAA};
        vecs[5] = '{mk4('h0100, 'h0200, 'hFF00, 'hFFFF),
                    mk4('h00FF, 'h0100, 'h0101, 'hFFFE),
                    mk8('h00FF, 'h0100, 'h0100, 'h0101, 'h0200, 'hFF00, 'hFFFE, 'hFFFF),
                    8'b10110010, 16'hFFFF};

        bus.sorted_i = '0;
        bus.valid_i  = 1'b0;
        bus.ready_i  = 1'b0;

        // Reset then idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready_o", 64'(bus.ready_o), 64'd1);
        chk("reset_valid_o", 64'(bus.valid_o), 64'd0);
        chk("reset_last_o", 64'(bus.last_o), 64'd0);
        bus.ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_valid_o", 64'(bus.valid_o), 64'd0);
        end
        chk("idle_ready_o", 64'(bus.ready_o), 64'd1);
        bus.ready_i = 1'b0;

        // Table-driven merge runs.
        for (int i = 0; i < 6; i++) begin
            load_chunk(vecs[i].a);
            load_chunk(vecs[i].b);
            drain(vecs[i].exp, vecs[i].src, vecs[i].rdy);
        end

        // Chunk offered throughout MERGE is ignored, then captured into A.
        load_chunk(vecs[0].a);
        load_chunk(vecs[0].b);
        bus.sorted_i = mk4(10, 11, 12, 13);
        bus.valid_i  = 1'b1;
        drain(vecs[0].exp, vecs[0].src, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        chk("late_offer_ready_o", 64'(bus.ready_o), 64'd1);
        chk("late_offer_valid_o", 64'(bus.valid_o), 64'd0);
        chk("late_offer_buf_a", 64'(dut.u_buf_a.mem_r), 64'(mk4(10, 11, 12, 13)));
        load_chunk(mk4(0, 1, 2, 3));
        drain(mk8(0, 1, 2, 3, 10, 11, 12, 13), 8'b11110000, 16'hFFFF);

        // Reset after three outputs, then a fresh run from the beginning.
        load_chunk(vecs[0].a);
        load_chunk(vecs[0].b);
        bus.ready_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_merged_o", 64'(bus.merged_o), 64'd4);
        rst = 1'b1;
        #1;
        chk("midrun_reset_valid_o", 64'(bus.valid_o), 64'd0);
        chk("midrun_reset_ready_o", 64'(bus.ready_o), 64'd1);
        chk("midrun_reset_last_o", 64'(bus.last_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b0;
        chk("midrun_reset_ia", 64'(dut.u_buf_a.ptr_r), 64'd0);
        chk("midrun_reset_ib", 64'(dut.u_buf_b.ptr_r), 64'd0);
        load_chunk(mk4(20, 22, 24, 26));
        load_chunk(mk4(21, 23, 25, 27));
        drain(mk8(20, 21, 22, 23, 24, 25, 26, 27), 8'b01010101, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
